// File: rtl/bounce_generator.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | bounce_generator: LFSR-driven mechanical-switch bounce emulator for          |
// | debouncer testing.  Revision 1.0                                             |
// +------------------------------------------------------------------------------+
module bounce_generator #(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned SETTLE_TICKS = 2000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clean_in,
    input  logic       enable,
    output logic       bouncy_out,
    output logic       busy,
    output logic [7:0] edge_count
);

    localparam int unsigned INTERVAL_MAX = 16 * TICK_DIV;
    localparam int unsigned SETTLE_MAX   = SETTLE_TICKS * TICK_DIV;
    localparam int unsigned INT_W        = $clog2(INTERVAL_MAX + 1);
    localparam int unsigned SET_W        = $clog2(SETTLE_MAX + 1);
    localparam logic [15:0] SEED_EFF     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_MAX);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BOUNCE = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             target_q, target_d;
    logic             out_q, out_d;
    logic [4:0]       remaining_q, remaining_d;
    logic [INT_W-1:0] interval_q, interval_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [7:0]       edges_q, edges_d;

    logic [4:0]       n_toggles;
    logic [INT_W-1:0] interval_load;
    logic             start_event;

    assign n_toggles     = {2'b00, lfsr_q[2:0]} + 5'd1;
    assign interval_load = INT_W'({1'b0, lfsr_q[6:3]} + 5'd1) * INT_W'(TICK_DIV);
    assign start_event   = enable && (clean_in != target_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_EFF;
            target_q    <= 1'b0;
            out_q       <= 1'b0;
            remaining_q <= '0;
            interval_q  <= '0;
            settle_q    <= '0;
            edges_q     <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            target_q    <= target_d;
            out_q       <= out_d;
            remaining_q <= remaining_d;
            interval_q  <= interval_d;
            settle_q    <= settle_d;
            edges_q     <= edges_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        target_d    = target_q;
        out_d       = out_q;
        remaining_d = remaining_q;
        interval_d  = interval_q;
        settle_d    = settle_q;
        edges_d     = edges_q;

        if (!enable) begin
            state_d     = S_IDLE;
            out_d       = clean_in;
            target_d    = clean_in;
            remaining_d = '0;
            interval_d  = '0;
            settle_d    = '0;
        end else if (start_event) begin
            // Restart has priority over a due toggle, so the restart cycle never toggles.
            state_d     = S_BOUNCE;
            target_d    = clean_in;
            edges_d     = '0;
            remaining_d = (out_q != clean_in) ? (n_toggles << 1) - 5'd1 : (n_toggles << 1);
            interval_d  = interval_load;
            settle_d    = '0;
        end else begin
            case (state_q)
                S_BOUNCE: begin
                    if (interval_q <= INT_W'(1)) begin
                        out_d       = ~out_q;
                        remaining_d = remaining_q - 5'd1;
                        edges_d     = (edges_q == 8'hFF) ? edges_q : edges_q + 8'd1;
                        if (remaining_q == 5'd1) begin
                            state_d    = S_SETTLE;
                            settle_d   = SETTLE_LOAD;
                            interval_d = '0;
                        end else begin
                            interval_d = interval_load;
                        end
                    end else begin
                        interval_d = interval_q - INT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (settle_q <= SET_W'(1)) begin
                        state_d  = S_IDLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        bouncy_out = out_q;
        edge_count = edges_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_bounce_generator: scoreboard bench with an event-time reference model.    |
// | Revision 1.0                                                                 |
// +------------------------------------------------------------------------------+
module tb_bounce_generator;

    localparam int TD = 2;
    localparam int ST = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clean_in = 1'b0;
    logic       enable = 1'b0;
    logic       bouncy_out;
    logic       busy;
    logic [7:0] edge_count;

    always #5 clk = ~clk;

    bounce_generator #(
        .TICK_DIV    (TD),
        .SETTLE_TICKS(ST),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clean_in  (clean_in),
        .enable    (enable),
        .bouncy_out(bouncy_out),
        .busy      (busy),
        .edge_count(edge_count)
    );

    typedef struct {
        logic o;
        logic b;
        int   e;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: toggles and settle end are scheduled as absolute edge numbers.
    logic [15:0] m_lfsr;
    logic        m_target, m_out;
    int          m_phase, m_left, m_next_t, m_settle_end, m_edges;
    int          cyc = 0;

    // Observation of the DUT for interval/latency properties.
    int   ivl_q[$];
    int   ref_cyc = 0;
    int   last_tog_cyc = 0;
    int   busy_fall_cyc = 0;
    logic last_seen_out = 1'b0;
    logic prev_busy = 1'b0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reset();
        m_lfsr   = 16'hACE1;
        m_target = 1'b0;
        m_out    = 1'b0;
        m_phase  = 0;
        m_left   = 0;
        m_edges  = 0;
    endtask

    task automatic model_edge();
        int          e;
        int          n;
        logic [15:0] lf;
        e  = cyc + 1;
        lf = m_lfsr;
        if (reset) begin
            model_reset();
            return;
        end
        if (!enable) begin
            m_phase  = 0;
            m_out    = clean_in;
            m_target = clean_in;
        end else if (clean_in != m_target) begin
            m_target = clean_in;
            m_edges  = 0;
            n        = int'(lf[2:0]) + 1;
            m_left   = (m_out != clean_in) ? 2 * n - 1 : 2 * n;
            m_next_t = e + (int'(lf[6:3]) + 1) * TD;
            m_phase  = 1;
        end else if (m_phase == 1 && e == m_next_t) begin
            m_out = ~m_out;
            if (m_edges < 255) m_edges++;
            m_left--;
            if (m_left == 0) begin
                m_phase      = 2;
                m_settle_end = e + ST * TD;
            end else begin
                m_next_t = e + (int'(lf[6:3]) + 1) * TD;
            end
        end else if (m_phase == 2 && e == m_settle_end) begin
            m_phase = 0;
        end
        m_lfsr = lfsr_next(lf);
    endtask

    task automatic step();
        exp_t x;
        model_edge();
        sb_q.push_back('{o: m_out, b: (m_phase != 0), e: m_edges});
        @(posedge clk);
        #1;
        cyc++;
        x = sb_q.pop_front();
        check_eq("bouncy_out", bouncy_out, x.o);
        check_eq("busy", busy, x.b);
        check_eq("edge_count", edge_count, x.e);
        if (!prev_busy && busy) ref_cyc = cyc;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        if (bouncy_out !== last_seen_out) begin
            ivl_q.push_back(cyc - ref_cyc);
            ref_cyc      = cyc;
            last_tog_cyc = cyc;
        end
        last_seen_out = bouncy_out;
        prev_busy     = busy;
    endtask

    task automatic run_to_idle(input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while (m_phase != 0 && k < budget);
        check_eq("idle_timeout", m_phase, 0);
    endtask

    initial begin
        model_reset();
        // Reset state with clean_in low, then 100 quiet cycles.
        repeat (3) step();
        check_eq("rst_out", bouncy_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_edges", edge_count, 0);
        reset  = 1'b0;
        enable = 1'b1;
        ivl_q.delete();
        repeat (100) step();
        check_eq("quiet_toggles", ivl_q.size(), 0);

        // Pass-through with enable low.
        enable = 1'b0;
        clean_in = 1'b1;
        step();
        check_eq("pass_out", bouncy_out, 1);
        check_eq("pass_busy", busy, 0);
        check_eq("pass_edges", edge_count, 0);
        clean_in = 1'b0;
        step();

        // Full bounce event 0 -> 1.
        ivl_q.delete();
        enable   = 1'b1;
        clean_in = 1'b1;
        run_to_idle(2000);
        check_eq("ev1_final", bouncy_out, 1);
        check_eq("ev1_odd", edge_count % 2, 1);
        check_eq("ev1_range", int'(edge_count >= 1 && edge_count <= 15), 1);
        check_eq("ev1_ntog", ivl_q.size(), edge_count);
        foreach (ivl_q[i]) begin
            check_eq("ev1_ivl_mod", ivl_q[i] % TD, 0);
            check_eq("ev1_ivl_rng", int'(ivl_q[i] >= 2 && ivl_q[i] <= 32), 1);
        end
        check_eq("ev1_settle", busy_fall_cyc - last_tog_cyc, ST * TD);

        // Restart mid-bounce while bouncy_out=0 toward target 0.
        enable   = 1'b0;
        clean_in = 1'b0;
        step();
        enable   = 1'b1;
        clean_in = 1'b1;
        step();
        step();
        check_eq("ev2_pre_out", bouncy_out, 0);
        clean_in = 1'b0;
        ivl_q.delete();
        step();
        check_eq("ev2_no_restart_tog", bouncy_out, 0);
        check_eq("ev2_restart_busy", busy, 1);
        run_to_idle(2000);
        check_eq("ev2_final", bouncy_out, 0);
        check_eq("ev2_even", edge_count % 2, 0);
        check_eq("ev2_ntog", ivl_q.size(), edge_count);

        // Asynchronous reset during bounce.
        clean_in = 1'b1;
        repeat (5) step();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("arst_out", bouncy_out, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_edges", edge_count, 0);
        last_seen_out = 1'b0;
        prev_busy     = 1'b0;
        repeat (3) step();
        clean_in = 1'b0;
        reset    = 1'b0;
        ivl_q.delete();
        repeat (40) step();
        check_eq("arst_quiet", ivl_q.size(), 0);

        // Held clean_in=1 at reset release starts on the first edge.
        reset = 1'b1;
        model_reset();
        repeat (2) step();
        clean_in = 1'b1;
        reset    = 1'b0;
        step();
        check_eq("rel_start_busy", busy, 1);
        run_to_idle(2000);

        // Enable dropped during settle.
        clean_in = 1'b0;
        begin
            int k = 0;
            do begin
                step();
                k++;
            end while (m_phase != 2 && k < 2000);
            check_eq("settle_reach", m_phase, 2);
        end
        step();
        enable   = 1'b0;
        clean_in = 1'b1;
        step();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_out", bouncy_out, 1);
        clean_in = 1'b0;
        step();
        check_eq("track_out0", bouncy_out, 0);
        clean_in = 1'b1;
        step();
        check_eq("track_out1", bouncy_out, 1);

        // Raising enable with clean_in == target does nothing.
        ivl_q.delete();
        enable = 1'b1;
        repeat (20) step();
        check_eq("noact_toggles", ivl_q.size(), 0);
        check_eq("noact_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bounce_generator.md
BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 Parameter TICK_DIV, default 1000: clock cycles per bounce tick (>=1).
REQ-002 Parameter SETTLE_TICKS, default 2000: ticks the settled level is held before busy drops (>=1).
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a zero value SHALL be replaced by 16'hACE1.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clean_in  input  1  ideal switch level, synchronous to clk.
REQ-007 enable  input  1  1 = bounce emulation on; 0 = clean pass-through.
REQ-008 bouncy_out  output  1  emulated mechanical-switch signal for a debouncer under test.
REQ-009 busy  output  1  high while a bounce or settle phase is in progress.
REQ-010 edge_count  output  8  number of bouncy_out toggles in the current or most recent event, saturating at 255.

Function
REQ-011 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock cycle while reset is low.
REQ-012 FSM states: IDLE, BOUNCE, SETTLE. A target register holds the last accepted clean_in level.
REQ-013 IDLE->BOUNCE SHALL occur on the first edge where enable=1 and clean_in != target.
- Target <= clean_in; edge_count <= 0.
- Remaining-toggle counter <= 2N-1 if bouncy_out != new target, else 2N, with N = lfsr[2:0]+1 (1..8).
REQ-014 On entering BOUNCE and after every toggle, the interval counter SHALL load (lfsr[6:3]+1)*TICK_DIV cycles (1..16 ticks).
REQ-015 In BOUNCE, at interval expiry, bouncy_out SHALL invert, remaining SHALL decrement, and edge_count SHALL increment (saturating).
REQ-016 When remaining reaches 0, the FSM SHALL enter SETTLE with bouncy_out equal to target.
REQ-017 SETTLE SHALL hold bouncy_out for SETTLE_TICKS*TICK_DIV cycles, then return to IDLE.
REQ-018 busy SHALL be 1 exactly in BOUNCE and SETTLE.
REQ-019 A clean_in change (clean_in != target) in BOUNCE or SETTLE SHALL restart the event per REQ-013/014 from the current bouncy_out level, with no extra toggle on the restart cycle.
REQ-020 The first toggle of an event SHALL never occur on the detection cycle; minimum latency is TICK_DIV cycles after detection.
REQ-021 With enable=0, the FSM SHALL be forced to IDLE and bouncy_out and target SHALL take clean_in one cycle later.
- edge_count SHALL hold its value.
- Deasserting enable mid-event SHALL abort the event within one cycle.
REQ-022 Raising enable while clean_in == target SHALL cause no activity.
REQ-023 Counters SHALL be sized for the parameters at defaults without overflow (interval up to 16*TICK_DIV; settle up to SETTLE_TICKS*TICK_DIV).
REQ-024 The final level of every completed event SHALL equal target; the total toggle count SHALL be odd if the starting level differs from target, even otherwise.

Reset
REQ-025 While reset is high:
- bouncy_out=0, busy=0, edge_count=0, target=0.
- State=IDLE, interval and settle counters=0, LFSR=seed.
REQ-026 Reset asserted mid-event SHALL clear all state immediately (asynchronously) with no further toggles.
REQ-027 After reset release, a held clean_in=1 with enable=1 SHALL start an event on the first clock edge.

Verification (TICK_DIV=2, SETTLE_TICKS=4, default seed)
REQ-028 Reset pulse with clean_in=0 -> bouncy_out=0, busy=0, edge_count=0; no toggles for 100 cycles.
REQ-029 enable=0, clean_in 0->1 -> bouncy_out=1 one cycle later; busy stays 0; edge_count unchanged.
REQ-030 enable=1, clean_in 0->1 held -> bouncy_out ends at 1.
- edge_count odd, in 1..15.
- Every toggle interval is a multiple of 2 cycles, in 2..32.
- busy falls exactly 8 cycles after the last toggle; results match a reference LFSR model cycle-exactly.
REQ-031 clean_in 1->0 mid-BOUNCE while bouncy_out=0 -> restart with even toggle count; final bouncy_out=0; no toggle on the restart cycle.
REQ-032 reset asserted during BOUNCE -> bouncy_out=0 and busy=0 within the same cycle (asynchronous), with no later toggles until a new event.
REQ-033 Enable dropped during SETTLE -> busy=0 next cycle; bouncy_out tracks clean_in with one-cycle latency.
